lupdate_mp: RTL and testbench

Parametrised successor to the local-update block. It sits on the 134-bit-style packet path between the report stage and the switch core, and forwards every packet with a fixed 3-cycle delay. Control packets addressed to the local MAC are decoded into writes on a bank of `NUM_REGS` configuration registers. Writes are staged in a shadow bank and committed atomically when the packet's tail arrives; control packets are optionally dropped from the output stream.

---
 rtl/lupdate_mp_pkg.sv | 17 +
 rtl/lupdate_mp_dly.sv | 76 +++++++
 rtl/lupdate_mp.sv | 161 ++++++++++++++++
 tb/tb_lupdate_mp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lupdate_mp_pkg.sv
// Shared constants and types for the lupdate_mp block.
//   FLAG_*   : values of the two-bit framing field at the top of the bus.
//   state_e  : parser FSM states.
//   CLS_BEAT : beat index at which a packet is classified.
//   DELAY    : depth of the forwarding delay line.
package lupdate_mp_pkg;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    localparam int unsigned CLS_BEAT = 2;
    localparam int unsigned DELAY    = 3;

    typedef enum logic [1:0] {IDLE, HDR, CTRL, DATA} state_e;

endpackage

// File: rtl/lupdate_mp_dly.sv
// Fixed-latency delay line for the packet path, with a per-packet drop mask.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   data_i/wr_i/valid_i/valid_wr_i : input word, strobe, descriptor, descriptor strobe
//   head_i                 : a strobed head beat is on the input this cycle
//   drop_set_i             : the packet currently being parsed must be dropped
//   data_o/wr_o/valid_o/valid_wr_o : outputs DELAY cycles later; strobes masked on drop
module lupdate_mp_dly
    import lupdate_mp_pkg::*;
#(
    parameter int unsigned W = 134
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_i,
    input  logic         wr_i,
    input  logic         valid_i,
    input  logic         valid_wr_i,
    input  logic         head_i,
    input  logic         drop_set_i,
    output logic [W-1:0] data_o,
    output logic         wr_o,
    output logic         valid_o,
    output logic         valid_wr_o
);

    // Each beat carries a small packet tag; drop decisions are stored per tag so a
    // late classification still reaches beats already in flight while older packets
    // in the line keep their own decision.
    logic [W-1:0]     data_q [DELAY];
    logic [1:0]       tag_q  [DELAY];
    logic [DELAY-1:0] wr_q;
    logic [DELAY-1:0] valid_q;
    logic [DELAY-1:0] valid_wr_q;
    logic [1:0]       cur_tag_q;
    logic [3:0]       drop_q;
    logic [1:0]       in_tag;

    assign in_tag = head_i ? cur_tag_q + 2'd1 : cur_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(DELAY); s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
            wr_q       <= '0;
            valid_q    <= '0;
            valid_wr_q <= '0;
            cur_tag_q  <= '0;
            drop_q     <= '0;
        end else begin
            cur_tag_q <= in_tag;
            if (head_i) begin
                drop_q[in_tag] <= 1'b0;
            end else if (drop_set_i) begin
                drop_q[cur_tag_q] <= 1'b1;
            end
            data_q[0] <= data_i;
            tag_q[0]  <= in_tag;
            for (int s = 1; s < int'(DELAY); s++) begin
                data_q[s] <= data_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
            wr_q       <= {wr_q[DELAY-2:0], wr_i};
            valid_q    <= {valid_q[DELAY-2:0], valid_i};
            valid_wr_q <= {valid_wr_q[DELAY-2:0], valid_wr_i};
        end
    end

    assign data_o     = data_q[DELAY-1];
    assign valid_o    = valid_q[DELAY-1];
    assign wr_o       = wr_q[DELAY-1] & ~drop_q[tag_q[DELAY-1]];
    assign valid_wr_o = valid_wr_q[DELAY-1] & ~drop_q[tag_q[DELAY-1]];

endmodule

// File: rtl/lupdate_mp.sv
// Local-update block: forwards packets with a fixed delay and turns control packets
// addressed to the local MAC into atomic writes on a bank of configuration registers.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   in_lu_data/_wr/_valid/_valid_wr    : packet input (flags, invalid-byte count, data)
//   in_local_mac_id                    : local MAC address
//   out_lu_data/_wr/_valid/_valid_wr   : delayed packet output, strobes masked on drop
//   out_local_mac_id                   : registered copy of the local MAC
//   cfg_regs                           : live registers, register i at [i*REG_W +: REG_W]
//   cfg_update                         : one-cycle pulse when a control packet commits
//   ctrl_pkt_cnt, bad_wr_cnt           : statistics, only with LUPDATE_MP_CNT_EN defined
module lupdate_mp
    import lupdate_mp_pkg::*;
#(
    parameter int unsigned DW        = 128,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_W     = 32,
    parameter logic [3:0]  CTRL_TYPE = 4'hf,
    parameter bit          DROP_CTRL = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DW+5:0]             in_lu_data,
    input  logic                      in_lu_data_wr,
    input  logic                      in_lu_data_valid,
    input  logic                      in_lu_data_valid_wr,
    input  logic [47:0]               in_local_mac_id,
    output logic [DW+5:0]             out_lu_data,
    output logic                      out_lu_data_wr,
    output logic                      out_lu_data_valid,
    output logic                      out_lu_data_valid_wr,
    output logic [47:0]               out_local_mac_id,
    output logic [NUM_REGS*REG_W-1:0] cfg_regs,
    output logic                      cfg_update
`ifdef LUPDATE_MP_CNT_EN
    ,
    output logic [31:0]               ctrl_pkt_cnt,
    output logic [31:0]               bad_wr_cnt
`endif
);

    logic [1:0]       flags;
    logic             is_head, is_mid, is_tail;
    state_e           state_q;
    logic [1:0]       beat_q;
    logic [REG_W-1:0] live_q   [NUM_REGS];
    logic [REG_W-1:0] shadow_q [NUM_REGS];
    logic [REG_W-1:0] shadow_d [NUM_REGS];
    logic             cfg_update_q;
    logic [47:0]      mac_q;
    logic [7:0]       wr_idx;
    logic             wr_en, wr_ok, commit, cls_now, cls_hit;

    assign flags   = in_lu_data[DW+5:DW+4];
    assign is_head = in_lu_data_wr && (flags == FLAG_HEAD);
    assign is_mid  = in_lu_data_wr && (flags == FLAG_MID);
    assign is_tail = in_lu_data_wr && (flags == FLAG_TAIL);

    assign wr_idx  = in_lu_data[DW-9:DW-16];
    assign wr_en   = (state_q == CTRL) && (is_mid || is_tail) && in_lu_data[DW-1];
    assign wr_ok   = wr_en && (32'(wr_idx) < NUM_REGS);
    assign commit  = (state_q == CTRL) && is_tail;
    assign cls_hit = (in_lu_data[DW-1:DW-48] == in_local_mac_id) &&
                     (in_lu_data[11:8] == CTRL_TYPE);
    // Reaching beat 2 while still in HDR implies the strobe was continuous.
    assign cls_now = (state_q == HDR) && (is_mid || is_tail) && (beat_q == 2'(CLS_BEAT));

    // Shadow next state: reload from live on any head (including aborts), else stage a write.
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) shadow_d[i] = shadow_q[i];
        if (is_head) begin
            for (int i = 0; i < int'(NUM_REGS); i++) shadow_d[i] = live_q[i];
        end else if (wr_ok) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_idx == 8'(i)) shadow_d[i] = in_lu_data[REG_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            cfg_update_q <= 1'b0;
            mac_q        <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            mac_q        <= in_local_mac_id;
            cfg_update_q <= commit;
            for (int i = 0; i < int'(NUM_REGS); i++) shadow_q[i] <= shadow_d[i];
            if (commit) begin
                for (int i = 0; i < int'(NUM_REGS); i++) live_q[i] <= shadow_d[i];
            end
            if (is_head) begin
                state_q <= HDR;
                beat_q  <= 2'd1;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    HDR: begin
                        if (!in_lu_data_wr) begin
                            state_q <= DATA;
                        end else if (is_tail) begin
                            state_q <= IDLE;
                        end else if (is_mid) begin
                            if (beat_q == 2'(CLS_BEAT)) state_q <= cls_hit ? CTRL : DATA;
                            else                        beat_q  <= beat_q + 2'd1;
                        end
                    end
                    CTRL, DATA: if (is_tail) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef LUPDATE_MP_CNT_EN
    logic [31:0] ctrl_cnt_q, bad_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (commit)          ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
            if (wr_en && !wr_ok) bad_cnt_q  <= bad_cnt_q + 32'd1;
        end
    end

    assign ctrl_pkt_cnt = ctrl_cnt_q;
    assign bad_wr_cnt   = bad_cnt_q;
`endif

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_cfg
        assign cfg_regs[g*REG_W +: REG_W] = live_q[g];
    end

    assign cfg_update       = cfg_update_q;
    assign out_local_mac_id = mac_q;

    lupdate_mp_dly #(
        .W (DW + 6)
    ) u_dly (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (in_lu_data),
        .wr_i       (in_lu_data_wr),
        .valid_i    (in_lu_data_valid),
        .valid_wr_i (in_lu_data_valid_wr),
        .head_i     (is_head),
        .drop_set_i (DROP_CTRL && cls_now && cls_hit),
        .data_o     (out_lu_data),
        .wr_o       (out_lu_data_wr),
        .valid_o    (out_lu_data_valid),
        .valid_wr_o (out_lu_data_valid_wr)
    );

endmodule

// File: tb/tb_lupdate_mp.sv
// Directed testbench for lupdate_mp with default parameters (DW=128, 8 x 32-bit regs).
module tb_lupdate_mp;

    localparam logic [1:0] FH = 2'b01;
    localparam logic [1:0] FM = 2'b11;
    localparam logic [1:0] FT = 2'b10;

    logic         clk;
    logic         rst_n;
    logic [133:0] in_lu_data;
    logic         in_lu_data_wr, in_lu_data_valid, in_lu_data_valid_wr;
    logic [47:0]  in_local_mac_id;
    logic [133:0] out_lu_data;
    logic         out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr;
    logic [47:0]  out_local_mac_id;
    logic [255:0] cfg_regs;
    logic         cfg_update;
`ifdef LUPDATE_MP_CNT_EN
    logic [31:0]  ctrl_pkt_cnt, bad_wr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_wr_n, out_vwr_n, upd_n;
    logic [133:0] in_words[$];
    int           in_cycs[$];
    logic [133:0] out_words[$];
    int           out_cycs[$];
    logic [31:0]  exp_regs [8];

    lupdate_mp dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_lu_data           (in_lu_data),
        .in_lu_data_wr        (in_lu_data_wr),
        .in_lu_data_valid     (in_lu_data_valid),
        .in_lu_data_valid_wr  (in_lu_data_valid_wr),
        .in_local_mac_id      (in_local_mac_id),
        .out_lu_data          (out_lu_data),
        .out_lu_data_wr       (out_lu_data_wr),
        .out_lu_data_valid    (out_lu_data_valid),
        .out_lu_data_valid_wr (out_lu_data_valid_wr),
        .out_local_mac_id     (out_local_mac_id),
        .cfg_regs             (cfg_regs),
        .cfg_update           (cfg_update)
`ifdef LUPDATE_MP_CNT_EN
        ,
        .ctrl_pkt_cnt         (ctrl_pkt_cnt),
        .bad_wr_cnt           (bad_wr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_lu_data_wr) begin
            out_wr_n++;
            out_words.push_back(out_lu_data);
            out_cycs.push_back(cyc);
        end
        if (out_lu_data_valid_wr) out_vwr_n++;
        if (cfg_update) upd_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] hdr2(input logic [47:0] mac);
        return {mac, 68'h0, 4'hf, 8'h00};
    endfunction

    function automatic logic [127:0] wrw(input logic en, input logic [7:0] idx,
                                         input logic [31:0] val);
        return {en, 7'h0, idx, 80'h0, val};
    endfunction

    task automatic drive(input logic [1:0] fl, input logic [127:0] d, input logic wr,
                         input logic vld);
        in_lu_data          = {fl, 4'h0, d};
        in_lu_data_wr       = wr;
        in_lu_data_valid    = vld;
        in_lu_data_valid_wr = vld;
        if (wr) begin
            in_words.push_back({fl, 4'h0, d});
            in_cycs.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, '0, 1'b0, 1'b0);
    endtask

    task automatic send_std(input logic [47:0] mac, input logic [127:0] w0,
                            input logic [127:0] w1);
        drive(FH, 128'h1111, 1'b1, 1'b0);
        drive(FM, 128'h2222, 1'b1, 1'b0);
        drive(FM, hdr2(mac), 1'b1, 1'b0);
        drive(FM, w0, 1'b1, 1'b0);
        drive(FT, w1, 1'b1, 1'b1);
    endtask

    task automatic clear_mon();
        out_wr_n = 0;
        out_vwr_n = 0;
        upd_n = 0;
        in_words.delete();
        in_cycs.delete();
        out_words.delete();
        out_cycs.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_local_mac_id = 48'h1;
        in_lu_data = '0;
        in_lu_data_wr = 1'b0;
        in_lu_data_valid = 1'b0;
        in_lu_data_valid_wr = 1'b0;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        #1;
        checks++; if (out_lu_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", out_lu_data); end
        checks++; if (out_lu_data_wr !== 1'b0 || out_lu_data_valid_wr !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b want 00", out_lu_data_wr, out_lu_data_valid_wr); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL rst_regs got %h want 0", cfg_regs); end
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL rst_update got %b want 0", cfg_update); end
        checks++; if (out_local_mac_id !== 48'h0) begin errors++; $display("FAIL rst_mac got %h want 0", out_local_mac_id); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_local_mac_id !== 48'h1) begin errors++; $display("FAIL mac_copy got %h want 1", out_local_mac_id); end
        idle(2);
    endtask

    task automatic test_ctrl_drop();
        clear_mon();
        drive(FH, 128'h1111, 1'b1, 1'b0);
        drive(FM, 128'h2222, 1'b1, 1'b0);
        drive(FM, hdr2(48'h1), 1'b1, 1'b0);
        drive(FM, wrw(1'b1, 8'd0, 32'hA5), 1'b1, 1'b0);
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL ctrl_staged got %h want 0", cfg_regs); end
        drive(FT, wrw(1'b1, 8'd3, 32'h1234), 1'b1, 1'b1);
        exp_regs[0] = 32'hA5;
        exp_regs[3] = 32'h1234;
        checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL ctrl_pulse got %b want 1", cfg_update); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL ctrl_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
        idle(1);
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL ctrl_pulse_end got %b want 0", cfg_update); end
        idle(4);
        checks++; if (upd_n !== 1) begin errors++; $display("FAIL ctrl_pulse_count got %0d want 1", upd_n); end
        checks++; if (out_wr_n !== 0 || out_vwr_n !== 0) begin errors++; $display("FAIL ctrl_dropped got %0d/%0d want 0/0", out_wr_n, out_vwr_n); end
`ifdef LUPDATE_MP_CNT_EN
        checks++; if (ctrl_pkt_cnt !== 32'd1) begin errors++; $display("FAIL ctrl_cnt got %0d want 1", ctrl_pkt_cnt); end
`endif
    endtask

    task automatic test_wrong_mac();
        clear_mon();
        send_std(48'h2, wrw(1'b1, 8'd0, 32'hFF), wrw(1'b1, 8'd3, 32'hFF));
        idle(5);
        checks++; if (out_wr_n !== 5) begin errors++; $display("FAIL fwd_count got %0d want 5", out_wr_n); end
        checks++; if (out_vwr_n !== 1) begin errors++; $display("FAIL fwd_vwr got %0d want 1", out_vwr_n); end
        for (int i = 0; i < in_words.size() && i < out_words.size(); i++) begin
            checks++; if (out_words[i] !== in_words[i]) begin errors++; $display("FAIL fwd_word%0d got %h want %h", i, out_words[i], in_words[i]); end
            checks++; if (out_cycs[i] !== in_cycs[i] + 3) begin errors++; $display("FAIL fwd_lat%0d got %0d want %0d", i, out_cycs[i], in_cycs[i] + 3); end
        end
        checks++; if (upd_n !== 0) begin errors++; $display("FAIL fwd_pulse got %0d want 0", upd_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL fwd_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
    endtask

    task automatic test_bad_idx();
        clear_mon();
        send_std(48'h1, wrw(1'b1, 8'd9, 32'hDEAD), wrw(1'b1, 8'd1, 32'h7));
        exp_regs[1] = 32'h7;
        idle(5);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL bad_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
        checks++; if (upd_n !== 1) begin errors++; $display("FAIL bad_pulse got %0d want 1", upd_n); end
`ifdef LUPDATE_MP_CNT_EN
        checks++; if (bad_wr_cnt !== 32'd1) begin errors++; $display("FAIL bad_cnt got %0d want 1", bad_wr_cnt); end
`endif
    endtask

    task automatic test_write_enable();
        clear_mon();
        send_std(48'h1, wrw(1'b0, 8'd2, 32'h55), wrw(1'b1, 8'd4, 32'h66));
        exp_regs[4] = 32'h66;
        idle(5);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL wen_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
    endtask

    task automatic test_abort();
        clear_mon();
        drive(FH, 128'h1111, 1'b1, 1'b0);
        drive(FM, 128'h2222, 1'b1, 1'b0);
        drive(FM, hdr2(48'h1), 1'b1, 1'b0);
        drive(FM, wrw(1'b1, 8'd5, 32'hBEEF), 1'b1, 1'b0);
        send_std(48'h1, wrw(1'b1, 8'd6, 32'h66), wrw(1'b0, 8'd5, 32'h1));
        exp_regs[6] = 32'h66;
        idle(5);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL abort_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
        checks++; if (upd_n !== 1) begin errors++; $display("FAIL abort_pulse got %0d want 1", upd_n); end
        checks++; if (out_wr_n !== 0) begin errors++; $display("FAIL abort_dropped got %0d want 0", out_wr_n); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        drive(FH, 128'hAAAA, 1'b1, 1'b0);
        drive(FT, 128'hBBBB, 1'b1, 1'b1);
        send_std(48'h1, wrw(1'b1, 8'd2, 32'h22), wrw(1'b1, 8'd7, 32'h77));
        exp_regs[2] = 32'h22;
        exp_regs[7] = 32'h77;
        idle(5);
        checks++; if (out_wr_n !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", out_wr_n); end
        checks++; if (out_vwr_n !== 1) begin errors++; $display("FAIL b2b_vwr got %0d want 1", out_vwr_n); end
        for (int i = 0; i < 2 && i < out_words.size(); i++) begin
            checks++; if (out_words[i] !== in_words[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, out_words[i], in_words[i]); end
            checks++; if (out_cycs[i] !== in_cycs[i] + 3) begin errors++; $display("FAIL b2b_lat%0d got %0d want %0d", i, out_cycs[i], in_cycs[i] + 3); end
        end
        checks++; if (upd_n !== 1) begin errors++; $display("FAIL b2b_pulse got %0d want 1", upd_n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL b2b_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive(FH, 128'h1111, 1'b1, 1'b0);
        drive(FM, 128'h2222, 1'b1, 1'b0);
        drive(FM, hdr2(48'h1), 1'b1, 1'b0);
        drive(FM, wrw(1'b1, 8'd0, 32'h99), 1'b1, 1'b0);
        in_lu_data_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
        checks++; if (out_lu_data !== '0) begin errors++; $display("FAIL rmid_data got %h want 0", out_lu_data); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL rmid_regs got %h want 0", cfg_regs); end
        checks++; if (out_local_mac_id !== 48'h0) begin errors++; $display("FAIL rmid_mac got %h want 0", out_local_mac_id); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(FT, wrw(1'b1, 8'd1, 32'h11), 1'b1, 1'b1);
        idle(5);
        checks++; if (upd_n !== 0) begin errors++; $display("FAIL rmid_no_commit got %0d want 0", upd_n); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL rmid_regs_after got %h want 0", cfg_regs); end
        checks++; if (out_wr_n !== 1) begin errors++; $display("FAIL rmid_stray_fwd got %0d want 1", out_wr_n); end
        send_std(48'h1, wrw(1'b1, 8'd4, 32'h44), wrw(1'b1, 8'd0, 32'h5));
        exp_regs[4] = 32'h44;
        exp_regs[0] = 32'h5;
        idle(5);
        for (int i = 0; i < 8; i++) begin
            checks++; if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin errors++; $display("FAIL rmid_reg%0d got %h want %h", i, cfg_regs[i*32 +: 32], exp_regs[i]); end
        end
        checks++; if (upd_n !== 1) begin errors++; $display("FAIL rmid_clean_pulse got %0d want 1", upd_n); end
        checks++; if (out_wr_n !== 1) begin errors++; $display("FAIL rmid_clean_drop got %0d want 1", out_wr_n); end
`ifdef LUPDATE_MP_CNT_EN
        checks++; if (ctrl_pkt_cnt !== 32'd1) begin errors++; $display("FAIL rmid_cnt got %0d want 1", ctrl_pkt_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_ctrl_drop();
        test_wrong_mac();
        test_bad_idx();
        test_write_enable();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
